// File: rtl/hds_rd_resp_splitter_if.sv
// Signal bundle for the HDS read-response splitter: command path, response path, routed outputs and status.
interface hds_rd_resp_splitter_if #(
    parameter int RAM_SEG_COUNT      = 2,
    parameter int RAM_SEG_DATA_WIDTH = 256,
    parameter int RAM_SEG_ADDR_WIDTH = 10,
    parameter int STAT_WIDTH         = 32
);
    logic                                                 split_en;
    logic [RAM_SEG_ADDR_WIDTH-1:0]                        split_addr;
    logic [RAM_SEG_COUNT-1:0][RAM_SEG_ADDR_WIDTH-1:0]     rd_cmd_addr;
    logic [RAM_SEG_COUNT-1:0]                             rd_cmd_valid;
    logic [RAM_SEG_COUNT-1:0]                             rd_cmd_ready_in;
    logic [RAM_SEG_COUNT-1:0]                             rd_cmd_ready;
    logic [RAM_SEG_COUNT-1:0][RAM_SEG_DATA_WIDTH-1:0]     rd_resp_data;
    logic [RAM_SEG_COUNT-1:0]                             rd_resp_valid;
    logic [RAM_SEG_COUNT-1:0]                             rd_resp_ready;
    logic [RAM_SEG_COUNT-1:0][RAM_SEG_DATA_WIDTH-1:0]     hdr_data;
    logic [RAM_SEG_COUNT-1:0]                             hdr_valid;
    logic [RAM_SEG_COUNT-1:0]                             hdr_ready;
    logic [RAM_SEG_COUNT-1:0][RAM_SEG_DATA_WIDTH-1:0]     pld_data;
    logic [RAM_SEG_COUNT-1:0]                             pld_valid;
    logic [RAM_SEG_COUNT-1:0]                             pld_ready;
    logic [RAM_SEG_COUNT-1:0]                             err_underflow;
    logic [STAT_WIDTH-1:0]                                hdr_beat_count;
    logic [STAT_WIDTH-1:0]                                pld_beat_count;

    modport master (
        output split_en, split_addr, rd_cmd_addr, rd_cmd_valid, rd_cmd_ready_in,
               rd_resp_data, rd_resp_valid, hdr_ready, pld_ready,
        input  rd_cmd_ready, rd_resp_ready, hdr_data, hdr_valid, pld_data, pld_valid,
               err_underflow, hdr_beat_count, pld_beat_count
    );

    modport slave (
        input  split_en, split_addr, rd_cmd_addr, rd_cmd_valid, rd_cmd_ready_in,
               rd_resp_data, rd_resp_valid, hdr_ready, pld_ready,
        output rd_cmd_ready, rd_resp_ready, hdr_data, hdr_valid, pld_data, pld_valid,
               err_underflow, hdr_beat_count, pld_beat_count
    );
endinterface

// File: rtl/hds_rd_resp_splitter.sv
// Header/data-split router for segmented DMA RAM read responses; per-segment class FIFO plus one output register.
// Optional beat counters enabled by defining HDS_STATS_EN.
module hds_rd_resp_splitter #(
    parameter int RAM_SEG_COUNT      = 2,
    parameter int RAM_SEG_DATA_WIDTH = 256,
    parameter int RAM_SEG_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH         = 8,
    parameter int STAT_WIDTH         = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    hds_rd_resp_splitter_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    for (genvar i = 0; i < RAM_SEG_COUNT; i++) begin : g_seg
        logic [FIFO_DEPTH-1:0]         cls_mem_q;
        logic [PW-1:0]                 wr_ptr_q, rd_ptr_q;
        logic [CW-1:0]                 cnt_q, cnt_d;
        logic                          out_vld_q, out_cls_q, err_q;
        logic [RAM_SEG_DATA_WIDTH-1:0] out_data_q;
        logic                          empty, cmd_ready, push, sel_ready, resp_ready, acc, pop, resp_cls;

        assign empty      = (cnt_q == '0);
        assign cmd_ready  = bus.rd_cmd_ready_in[i] & (cnt_q != FULL);
        assign push       = bus.rd_cmd_valid[i] & cmd_ready;
        assign sel_ready  = out_cls_q ? bus.hdr_ready[i] : bus.pld_ready[i];
        assign resp_ready = ~out_vld_q | sel_ready;
        assign acc        = bus.rd_resp_valid[i] & resp_ready;
        assign pop        = acc & ~empty;
        // A beat with no matching command is forced onto the payload path.
        assign resp_cls   = ~empty & cls_mem_q[rd_ptr_q];
        assign cnt_d      = cnt_q + CW'(push) - CW'(pop);

        always_ff @(posedge clk) begin
            if (rst) begin
                cls_mem_q  <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                cnt_q      <= '0;
                out_vld_q  <= 1'b0;
                out_cls_q  <= 1'b0;
                out_data_q <= '0;
                err_q      <= 1'b0;
            end else begin
                if (push) begin
                    cls_mem_q[wr_ptr_q] <= bus.split_en & (bus.rd_cmd_addr[i] < bus.split_addr);
                    wr_ptr_q            <= wr_ptr_q + 1'b1;
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                cnt_q <= cnt_d;
                if (acc) begin
                    out_vld_q  <= 1'b1;
                    out_cls_q  <= resp_cls;
                    out_data_q <= bus.rd_resp_data[i];
                end else if (sel_ready) begin
                    out_vld_q  <= 1'b0;
                end
                if (acc & empty)
                    err_q <= 1'b1;
            end
        end

        assign bus.rd_cmd_ready[i]  = cmd_ready;
        assign bus.rd_resp_ready[i] = resp_ready;
        assign bus.hdr_valid[i]     = out_vld_q & out_cls_q;
        assign bus.pld_valid[i]     = out_vld_q & ~out_cls_q;
        assign bus.hdr_data[i]      = out_data_q;
        assign bus.pld_data[i]      = out_data_q;
        assign bus.err_underflow[i] = err_q;
    end

`ifdef HDS_STATS_EN
    logic [STAT_WIDTH-1:0] hdr_cnt_q, hdr_cnt_d, pld_cnt_q, pld_cnt_d;

    always_comb begin
        hdr_cnt_d = hdr_cnt_q;
        pld_cnt_d = pld_cnt_q;
        for (int k = 0; k < RAM_SEG_COUNT; k++) begin
            hdr_cnt_d = hdr_cnt_d + STAT_WIDTH'(bus.hdr_valid[k] & bus.hdr_ready[k]);
            pld_cnt_d = pld_cnt_d + STAT_WIDTH'(bus.pld_valid[k] & bus.pld_ready[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt_q <= '0;
            pld_cnt_q <= '0;
        end else begin
            hdr_cnt_q <= hdr_cnt_d;
            pld_cnt_q <= pld_cnt_d;
        end
    end

    assign bus.hdr_beat_count = hdr_cnt_q;
    assign bus.pld_beat_count = pld_cnt_q;
`else
    assign bus.hdr_beat_count = '0;
    assign bus.pld_beat_count = '0;
`endif
endmodule

// File: tb/tb_hds_rd_resp_splitter.sv
// Randomized bench for hds_rd_resp_splitter against a queue-based transaction model.
module tb_hds_rd_resp_splitter;
    localparam int SEG   = 2;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam int SW    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hds_rd_resp_splitter_if #(.RAM_SEG_COUNT(SEG), .RAM_SEG_DATA_WIDTH(DW),
                              .RAM_SEG_ADDR_WIDTH(AW), .STAT_WIDTH(SW)) bus ();

    hds_rd_resp_splitter #(.RAM_SEG_COUNT(SEG), .RAM_SEG_DATA_WIDTH(DW), .RAM_SEG_ADDR_WIDTH(AW),
                           .FIFO_DEPTH(DEPTH), .STAT_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: in-order classes per segment, pending output beat, sticky error, beat totals.
    bit              cq[SEG][$];
    bit              m_vld[SEG];
    bit              m_cls[SEG];
    bit              m_err[SEG];
    logic [DW-1:0]   m_dat[SEG];
    logic [SW-1:0]   m_hcnt, m_pcnt;

    int cmd_p, resp_p, rin_p, hrdy_p, prdy_p, sen_mode;

    task automatic model_reset();
        for (int i = 0; i < SEG; i++) begin
            cq[i].delete();
            m_vld[i] = 0; m_cls[i] = 0; m_err[i] = 0; m_dat[i] = '0;
        end
        m_hcnt = '0;
        m_pcnt = '0;
    endtask

    task automatic model_step();
        bit cr, sel, rr, c;
        for (int i = 0; i < SEG; i++) begin
            cr  = bus.rd_cmd_ready_in[i] && (cq[i].size() < DEPTH);
            sel = m_cls[i] ? bus.hdr_ready[i] : bus.pld_ready[i];
            rr  = !m_vld[i] || sel;
            if (m_vld[i] && m_cls[i] && bus.hdr_ready[i])  m_hcnt++;
            if (m_vld[i] && !m_cls[i] && bus.pld_ready[i]) m_pcnt++;
            if (bus.rd_resp_valid[i] && rr) begin
                if (cq[i].size() == 0) begin
                    c = 0;
                    m_err[i] = 1;
                end else begin
                    c = cq[i].pop_front();
                end
                m_vld[i] = 1;
                m_cls[i] = c;
                m_dat[i] = bus.rd_resp_data[i];
            end else if (sel) begin
                m_vld[i] = 0;
            end
            if (bus.rd_cmd_valid[i] && cr)
                cq[i].push_back(bus.split_en && (int'(bus.rd_cmd_addr[i]) < int'(bus.split_addr)));
        end
    endtask

    task automatic check_all();
        logic [SW-1:0] eh, ep;
        for (int i = 0; i < SEG; i++) begin
            chk($sformatf("cmd_ready%0d", i), 64'(bus.rd_cmd_ready[i]),
                64'(bus.rd_cmd_ready_in[i] && cq[i].size() < DEPTH));
            chk($sformatf("resp_ready%0d", i), 64'(bus.rd_resp_ready[i]),
                64'(!m_vld[i] || (m_cls[i] ? bus.hdr_ready[i] : bus.pld_ready[i])));
            chk($sformatf("hdr_valid%0d", i), 64'(bus.hdr_valid[i]), 64'(m_vld[i] && m_cls[i]));
            chk($sformatf("pld_valid%0d", i), 64'(bus.pld_valid[i]), 64'(m_vld[i] && !m_cls[i]));
            chk($sformatf("hdr_data%0d", i), 64'(bus.hdr_data[i]), 64'(m_dat[i]));
            chk($sformatf("pld_data%0d", i), 64'(bus.pld_data[i]), 64'(m_dat[i]));
            chk($sformatf("err%0d", i), 64'(bus.err_underflow[i]), 64'(m_err[i]));
        end
`ifdef HDS_STATS_EN
        eh = m_hcnt;
        ep = m_pcnt;
`else
        eh = '0;
        ep = '0;
`endif
        chk("hdr_cnt", 64'(bus.hdr_beat_count), 64'(eh));
        chk("pld_cnt", 64'(bus.pld_beat_count), 64'(ep));
    endtask

    task automatic drive();
        bus.split_en = (sen_mode == 2) ? 1'($urandom_range(1)) : 1'(sen_mode);
        if ($urandom_range(9) == 0)
            bus.split_addr = ($urandom_range(3) == 0) ? AW'(0) : AW'($urandom_range(16));
        for (int i = 0; i < SEG; i++) begin
            bus.rd_cmd_valid[i]    = ($urandom_range(99) < cmd_p);
            bus.rd_cmd_addr[i]     = ($urandom_range(15) == 0) ? AW'(1023) : AW'($urandom_range(20));
            bus.rd_cmd_ready_in[i] = ($urandom_range(99) < rin_p);
            bus.rd_resp_valid[i]   = ($urandom_range(99) < resp_p);
            bus.rd_resp_data[i]    = DW'($urandom);
            bus.hdr_ready[i]       = ($urandom_range(99) < hrdy_p);
            bus.pld_ready[i]       = ($urandom_range(99) < prdy_p);
        end
    endtask

    task automatic step(input bit do_rst);
        @(negedge clk);
        rst = do_rst;
        drive();
        #1;
        check_all();
        if (do_rst) model_reset();
        else        model_step();
    endtask

    task automatic phase(input int n, input int cp, input int rp, input int ri,
                         input int hp, input int pp, input int sm);
        cmd_p = cp; resp_p = rp; rin_p = ri; hrdy_p = hp; prdy_p = pp; sen_mode = sm;
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.split_en   = 1'b0;
        bus.split_addr = AW'(4);
        bus.rd_cmd_addr = '0; bus.rd_cmd_valid = '0; bus.rd_cmd_ready_in = '0;
        bus.rd_resp_data = '0; bus.rd_resp_valid = '0; bus.hdr_ready = '0; bus.pld_ready = '0;
        model_reset();
        cmd_p = 0; resp_p = 0; rin_p = 100; hrdy_p = 100; prdy_p = 100; sen_mode = 1;
        step(1'b1);
        step(1'b1);
        phase(10,   0,   0, 100, 100, 100, 1);   // idle after reset
        phase(400, 60,  50,  80,  70,  70, 2);   // mixed traffic
        phase(20,  100,  0, 100, 100, 100, 1);   // fill FIFOs to full
        phase(30,   50, 100, 100,   0, 100, 1);  // header path stalled
        phase(200,  60,  55,  90,  80,  80, 0);  // split disabled: all payload
        phase(10,  100,  0, 100, 100, 100, 1);
        step(1'b1);                              // reset mid-burst
        phase(10,    0,  0, 100, 100, 100, 1);
        phase(5,     0, 100, 100, 100, 100, 1);  // responses with no commands
        phase(300,  70,  60,  85,  60,  90, 2);
        phase(200, 100, 100, 100, 100, 100, 2);  // continuous streaming
        phase(20,    0,   0, 100, 100, 100, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
